// File: rtl/cpu_params_pkg.sv
// Shared parameters for the timer / software-interrupt register window:
// register width, register offsets, select-vector bit positions, FSM states.
package cpu_params_pkg;

  localparam int RSZ = 32;

  localparam logic [RSZ-1:0] OFF_MSIP        = 32'h0000_0000;
  localparam logic [RSZ-1:0] OFF_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [RSZ-1:0] OFF_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [RSZ-1:0] OFF_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [RSZ-1:0] OFF_MTIME_HI    = 32'h0000_BFFC;

  // Bit positions inside the one-hot register select vector
  localparam int SEL_W      = 5;
  localparam int SEL_MSIP   = 0;
  localparam int SEL_CMP_LO = 1;
  localparam int SEL_CMP_HI = 2;
  localparam int SEL_MT_LO  = 3;
  localparam int SEL_MT_HI  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } mmr_state_t;

endpackage

// File: rtl/mmr_ctrl_if.sv
// Request/response handshake bus between a load/store unit and mmr_ctrl.
interface mmr_ctrl_if;
  import cpu_params_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic           req_rd;
  logic [RSZ-1:0] req_addr;
  logic [RSZ-1:0] req_wr_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [RSZ-1:0] rsp_rd_data;
  logic           rsp_err;

  modport master (
    output req_valid, req_rd, req_addr, req_wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_err
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_data, rsp_err
  );

endinterface

// File: rtl/mmr_decode.sv
// Combinational address decode: byte address -> one-hot register select.
// err is set whenever no register is selected (misaligned, unmapped offset
// inside the window, or outside the window altogether).
module mmr_decode
  import cpu_params_pkg::*;
#(
  parameter logic [RSZ-1:0] MMR_BASE = 32'h0200_0000,
  parameter logic [RSZ-1:0] MMR_SPAN = 32'h0001_0000
) (
  input  logic [RSZ-1:0]   addr,
  output logic [SEL_W-1:0] sel,
  output logic             err
);

  logic [RSZ-1:0] offset;
  logic           in_win;
  logic           aligned;

  // Window check, alignment check and offset match
  always_comb begin
    offset  = addr - MMR_BASE;
    in_win  = (addr >= MMR_BASE) && (offset < MMR_SPAN);
    aligned = (addr[1:0] == 2'b00);
    sel     = '0;
    if (in_win && aligned) begin
      case (offset)
        OFF_MSIP:        sel[SEL_MSIP]   = 1'b1;
        OFF_MTIMECMP_LO: sel[SEL_CMP_LO] = 1'b1;
        OFF_MTIMECMP_HI: sel[SEL_CMP_HI] = 1'b1;
        OFF_MTIME_LO:    sel[SEL_MT_LO]  = 1'b1;
        OFF_MTIME_HI:    sel[SEL_MT_HI]  = 1'b1;
        default:         sel             = '0;
      endcase
    end
    err = ~|sel;
  end

endmodule

// File: rtl/mmr_ctrl.sv
// Timer / software-interrupt register window controller.
// Three-state handshake FSM; write strobes go to the interrupt controller,
// reads sample live timer state. MTIME is read as two halves: reading the
// low half freezes the high half in a shadow so a following high-half read
// is coherent with it even if the timer carried in between.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | req_ready high, waiting for a request
//   ST_EXEC | decode captured address, pulse write strobe, sample read data
//   ST_RESP | rsp_valid held with stable data until rsp_ready
module mmr_ctrl
  import cpu_params_pkg::*;
#(
  parameter logic [RSZ-1:0] MMR_BASE = 32'h0200_0000,
  parameter logic [RSZ-1:0] MMR_SPAN = 32'h0001_0000
) (
  input  logic             clk_in,
  input  logic             reset_in,
  mmr_ctrl_if.slave        bus,
  output logic             msip_wr,
  output logic             mtime_lo_wr,
  output logic             mtime_hi_wr,
  output logic             mtimecmp_lo_wr,
  output logic             mtimecmp_hi_wr,
  output logic [RSZ-1:0]   mmr_wr_data,
  input  logic [2*RSZ-1:0] mtime,
  input  logic [2*RSZ-1:0] mtimecmp,
  input  logic             sw_irq
);

  mmr_state_t       state;
  logic [RSZ-1:0]   addr_q;
  logic             rd_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [RSZ-1:0]   rsp_data_q;
  logic [RSZ-1:0]   shadow;
  logic             shadow_vld;
  logic [SEL_W-1:0] sel;
  logic             dec_err;
  logic             wr_exec;
  logic [RSZ-1:0]   rd_mux;

  mmr_decode #(
    .MMR_BASE (MMR_BASE),
    .MMR_SPAN (MMR_SPAN)
  ) u_decode (
    .addr (addr_q),
    .sel  (sel),
    .err  (dec_err)
  );

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rd_data = rsp_data_q;

  // Strobes come only from registered state and the captured address, so
  // they are high for exactly the one EXEC cycle of a mapped write.
  assign wr_exec        = (state == ST_EXEC) && !rd_q;
  assign msip_wr        = wr_exec && sel[SEL_MSIP];
  assign mtimecmp_lo_wr = wr_exec && sel[SEL_CMP_LO];
  assign mtimecmp_hi_wr = wr_exec && sel[SEL_CMP_HI];
  assign mtime_lo_wr    = wr_exec && sel[SEL_MT_LO];
  assign mtime_hi_wr    = wr_exec && sel[SEL_MT_HI];

  // Read data select; zero when nothing is selected (error)
  always_comb begin
    rd_mux = '0;
    if (sel[SEL_MSIP])   rd_mux = {{(RSZ-4){1'b0}}, sw_irq, 3'b000};
    if (sel[SEL_CMP_LO]) rd_mux = mtimecmp[RSZ-1:0];
    if (sel[SEL_CMP_HI]) rd_mux = mtimecmp[2*RSZ-1:RSZ];
    if (sel[SEL_MT_LO])  rd_mux = mtime[RSZ-1:0];
    if (sel[SEL_MT_HI])  rd_mux = shadow_vld ? shadow : mtime[2*RSZ-1:RSZ];
  end

  // Handshake FSM, request capture, response registers and mtime shadow
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      mmr_wr_data <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      shadow      <= '0;
      shadow_vld  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            rd_q        <= bus.req_rd;
            mmr_wr_data <= bus.req_wr_data;
            req_ready_q <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= dec_err;
          rsp_data_q  <= rd_q ? rd_mux : '0;
          if (rd_q && sel[SEL_MT_LO]) begin
            shadow     <= mtime[2*RSZ-1:RSZ];
            shadow_vld <= 1'b1;
          end
          if (rd_q && sel[SEL_MT_HI]) shadow_vld <= 1'b0;
          if (!rd_q && (sel[SEL_MT_LO] || sel[SEL_MT_HI])) shadow_vld <= 1'b0;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmr_ctrl.md
MMR_CTRL -- requirements
Module: mmr_ctrl

Interface
REQ-001 Parameter: MMR_BASE, default 32'h0200_0000, byte base of the timer/software-interrupt register window.
REQ-002 Parameter: MMR_SPAN, default 32'h0001_0000, window size in bytes.
REQ-003 Port: clk_in  input  1  single clock; one clock domain.
REQ-004 Port: reset_in  input  1  reset is asynchronous and active-low.
REQ-005 Port: req_valid  input  1  load/store request present.
REQ-006 Port: req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 Port: req_rd  input  1  1 = read, 0 = write.
REQ-008 Port: req_addr  input  RSZ  byte address.
REQ-009 Port: req_wr_data  input  RSZ  store data.
REQ-010 Port: rsp_valid  output  1  response present.
REQ-011 Port: rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-012 Port: rsp_rd_data  output  RSZ  load data; 0 on writes and errors.
REQ-013 Port: rsp_err  output  1  misaligned or unmapped access.
REQ-014 Ports, all outputs, 1 bit each: msip_wr, mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr; these are single-cycle write strobes to the interrupt controller.
REQ-015 Port: mmr_wr_data  output  RSZ  write data qualified by the strobes.
REQ-016 Port: mtime  input  2*RSZ  live timer value.
REQ-017 Port: mtimecmp  input  2*RSZ  compare value.
REQ-018 Port: sw_irq  input  1  current MSIP bit.

Function
REQ-019 Offsets from MMR_BASE: MSIP 0x0000, MTIMECMP_LO 0x4000, MTIMECMP_HI 0x4004, MTIME_LO 0xBFF8, MTIME_HI 0xBFFC.
REQ-020 FSM states IDLE, EXEC, RESP; req_ready = 1 only in IDLE.
REQ-021 IDLE -> EXEC on accept; address, rd flag and write data are captured into registers.
REQ-022 EXEC -> RESP unconditionally after one cycle; decode, write strobe and read sampling all occur in EXEC.
REQ-023 RESP: rsp_valid held high with stable data until rsp_ready; RESP -> IDLE on handshake.
REQ-024 Latency: rsp_valid rises 2 cycles after the accept edge; the next request can be accepted the cycle after the response handshake.
REQ-025 Write to a valid register: exactly one matching strobe is high for the single EXEC cycle; mmr_wr_data = captured data; all other strobes are 0.
REQ-026 Errors: addr[1:0] != 0, or an in-window offset not listed in REQ-019 -> rsp_err = 1, no strobe, rsp_rd_data = 0.
REQ-027 Out-of-window addresses are treated as errors in the same way.
REQ-028 MSIP read returns {(RSZ-4)'0, sw_irq, 3'b0}.
REQ-029 MTIMECMP_LO/HI reads return mtimecmp[RSZ-1:0] and mtimecmp[2*RSZ-1:RSZ] respectively.
REQ-030 Coherent mtime read: a MTIME_LO read returns mtime[RSZ-1:0] and latches mtime[2*RSZ-1:RSZ] into a shadow register, setting shadow_vld.
REQ-031 A MTIME_HI read returns the shadow when shadow_vld = 1, otherwise live mtime[2*RSZ-1:RSZ]; the MTIME_HI read clears shadow_vld.
REQ-032 Any write to MTIME_LO or MTIME_HI clears shadow_vld.
REQ-033 Read data is sampled in EXEC and registered; it is not re-sampled while in RESP.
REQ-034 req_valid is ignored outside IDLE; rsp_ready is ignored outside RESP.

Reset
REQ-035 Asserting reset_in (low) asynchronously forces: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rd_data 0, all strobes 0, mmr_wr_data 0, shadow 0, shadow_vld 0.
REQ-036 Reset mid-transaction abandons it; no strobe and no response are produced after deassertion.
REQ-037 Release of reset_in is synchronised externally; the block requires no internal reset synchroniser.

Structure
REQ-038 Offset constants and the state enum reside in cpu_params_pkg; RSZ is taken from that package.
REQ-039 One sub-module, mmr_decode (combinational address -> one-hot register select plus error flag), is instantiated once.

Verification
REQ-040 Write 0x0000_0008 to MMR_BASE+0x0000 -> msip_wr high exactly one cycle, mmr_wr_data = 0x8, rsp_valid 2 cycles after accept, rsp_err = 0.
REQ-041 Set mtime = 0x0000_0001_FFFF_FFFF; read MTIME_LO -> 0xFFFF_FFFF; advance mtime to 0x0000_0002_0000_0005; read MTIME_HI -> 0x0000_0001.
REQ-042 Read MTIME_HI without a prior LO read, mtime = 0x0000_0007_0000_0000 -> returns 0x0000_0007.
REQ-043 Write to MMR_BASE+0x4002 and read MMR_BASE+0x1000 -> rsp_err = 1, no strobe, rd_data 0.
REQ-044 Hold rsp_ready low 5 cycles -> rsp_valid and data stable, req_ready 0 throughout.
REQ-045 Assert reset_in during EXEC of a MTIMECMP_HI write -> strobe low, rsp_valid 0, FSM in IDLE after release.
